// File: rtl/shift_pkg.sv
// Shared constants, FSM state type and pass-amount helper for the
// barrel-shift sequencer slice.
//   WIDTH    : data width of the operand and result
//   SAMT_W   : amount width accepted by the combinational shifter
//   AMT_W    : amount width accepted by the sequencer (total shift)
//   MAX_PASS : largest amount a single shifter pass can apply
package shift_pkg;

  localparam int WIDTH    = 64;
  localparam int SAMT_W   = 5;
  localparam int AMT_W    = 6;
  localparam int MAX_PASS = (1 << SAMT_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Amount applied in the next pass: min(rem, MAX_PASS).
  function automatic logic [SAMT_W-1:0] pass_amt(input logic [AMT_W-1:0] rem);
    if (int'(rem) > MAX_PASS) return SAMT_W'(MAX_PASS);
    else                      return rem[SAMT_W-1:0];
  endfunction

endpackage

// File: rtl/shift_ovf_detect.sv
// Combinational overflow detector for one arithmetic-left pass.
// Ports:
//   work : value about to be shifted
//   s    : amount of this pass (0 means nothing is lost)
//   lost : high when any of the s bits just below the sign bit, which
//          fall off the top during this pass, differs from the sign bit
module shift_ovf_detect
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0]  work,
  input  logic [SAMT_W-1:0] s,
  output logic              lost
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] ones_s;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] diff;

  // s ones, moved up so they cover bits [WIDTH-2 : WIDTH-1-s].
  assign ones_s = (ONE << s) - ONE;
  assign mask   = ones_s << (WIDTH - 1 - int'(s));
  assign diff   = work ^ {WIDTH{work[WIDTH-1]}};
  assign lost   = |(diff & mask);

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Issue/sequencing stage for a 64-bit combinational arithmetic-left
// barrel shifter that handles at most MAX_PASS per pass. A request with
// a total amount of 0..63 is split into passes of up to MAX_PASS,
// each result fed back into a working register, with a sticky overflow.
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid/in_ready    : request handshake, D_in operand, amt total shift
//   sh_D_in/sh_samt      : drive the external shifter
//   sh_D_out             : shifter result (combinational, same cycle)
//   out_valid/out_ready  : result handshake, D_out result, ovf overflow
module barrel_shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  D_in,
  input  logic [AMT_W-1:0]  amt,
  output logic [WIDTH-1:0]  sh_D_in,
  output logic [SAMT_W-1:0] sh_samt,
  input  logic [WIDTH-1:0]  sh_D_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  D_out,
  output logic              ovf
);

  state_e             state;
  logic [WIDTH-1:0]   work;
  logic [AMT_W-1:0]   rem;
  logic               ovf_r;

  logic [SAMT_W-1:0]  s;
  logic [AMT_W-1:0]   rem_next;
  logic               lost;
  logic               accept;

  // Pass amount is forced to 0 outside SHIFT so the shifter and the
  // overflow detector see a neutral amount while idle or holding a result.
  assign s        = (state == SHIFT) ? pass_amt(rem) : '0;
  assign rem_next = rem - AMT_W'(s);

  assign sh_D_in  = work;
  assign sh_samt  = s;

  // In DONE a new request may only enter in the cycle the result leaves.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  // All result outputs come straight from registers, so they are glitch-free.
  assign out_valid = (state == DONE);
  assign D_out     = work;
  assign ovf       = ovf_r;

  shift_ovf_detect u_ovf_detect (
    .work (work),
    .s    (s),
    .lost (lost)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= D_in;
            rem   <= amt;
            ovf_r <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= sh_D_out;
          rem   <= rem_next;
          ovf_r <= ovf_r | lost;
          // amt == 0 still spends exactly one pass here with s == 0.
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (accept) begin
            // Back-to-back: load the next request while the result is taken.
            work  <= D_in;
            rem   <= amt;
            ovf_r <= 1'b0;
            state <= SHIFT;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
